// File: rtl/dct_pkg.sv
// Shared types and sizes for the 1-D forward DCT pipeline (row loader and fdct stages).
package dct_pkg;

  localparam int unsigned DCT_N = 8;
  localparam int unsigned PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t [DCT_N-1:0] row_t;

endpackage

// File: rtl/dct_row_bank.sv
// One ping-pong bank: N x WIDTH sample storage plus the full flag that hands it to the reader.
module dct_row_bank
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned N     = DCT_N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic [$clog2(N)-1:0] i_wr_idx,
  input  logic [WIDTH-1:0]     i_wr_data,
  input  logic                 i_set_full,
  input  logic                 i_clr_full,
  output logic                 o_full,
  output logic [WIDTH-1:0]     o_data [N-1:0]
);

  logic [WIDTH-1:0] r_mem [N-1:0];
  logic             r_full;

  // Writes are gated by the top so a FULL bank is never overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(N); k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  // Set (last write) and clear (drain) never coincide: a bank is written only while not full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 1'b0;
    end else if (i_set_full) begin
      r_full <= 1'b1;
    end else if (i_clr_full) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_mem;

endmodule

// File: rtl/dct_row_loader.sv
// Pixel-stream to row-vector deserializer with ping-pong banks for the 1-D DCT.
// Optional feature: DCT_LEVEL_SHIFT_EN stores each sample with its MSB inverted (unsigned -> signed).
module dct_row_loader
  import dct_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned N     = DCT_N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data [N-1:0],
  output logic [$clog2(N)-1:0] m_row
);

  localparam int unsigned IDX_W = $clog2(N);

  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [IDX_W-1:0] r_wr_idx;
  logic [IDX_W-1:0] r_m_row;

  logic             w_full0;
  logic             w_full1;
  logic [WIDTH-1:0] w_data0 [N-1:0];
  logic [WIDTH-1:0] w_data1 [N-1:0];
  logic [WIDTH-1:0] w_wr_data;
  logic             w_s_fire;
  logic             w_m_fire;
  logic             w_last;
  logic             w_wr_en0;
  logic             w_wr_en1;
  logic             w_clr0;
  logic             w_clr1;

`ifdef DCT_LEVEL_SHIFT_EN
  assign w_wr_data = {~s_data[WIDTH-1], s_data[WIDTH-2:0]};
`else
  assign w_wr_data = s_data;
`endif

  // Handshake decodes; s_ready/m_valid come only from registered bank state.
  assign s_ready  = r_wr_bank ? ~w_full1 : ~w_full0;
  assign m_valid  = r_rd_bank ? w_full1 : w_full0;
  assign w_s_fire = s_valid & s_ready;
  assign w_m_fire = m_valid & m_ready;
  assign w_last   = (r_wr_idx == IDX_W'(N - 1));

  assign w_wr_en0 = w_s_fire & ~r_wr_bank;
  assign w_wr_en1 = w_s_fire &  r_wr_bank;
  assign w_clr0   = w_m_fire & ~r_rd_bank;
  assign w_clr1   = w_m_fire &  r_rd_bank;

  dct_row_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank0 (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_wr_en0),
    .i_wr_idx   (r_wr_idx),
    .i_wr_data  (w_wr_data),
    .i_set_full (w_wr_en0 & w_last),
    .i_clr_full (w_clr0),
    .o_full     (w_full0),
    .o_data     (w_data0)
  );

  dct_row_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank1 (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_wr_en1),
    .i_wr_idx   (r_wr_idx),
    .i_wr_data  (w_wr_data),
    .i_set_full (w_wr_en1 & w_last),
    .i_clr_full (w_clr1),
    .o_full     (w_full1),
    .o_data     (w_data1)
  );

  // Write pointer: advance per accepted sample, flip banks after the N-th.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_bank <= 1'b0;
      r_wr_idx  <= '0;
    end else if (w_s_fire) begin
      if (w_last) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_idx  <= '0;
      end else begin
        r_wr_idx  <= r_wr_idx + IDX_W'(1);
      end
    end
  end

  // Read pointer and row tag; N is a power of two so the tag wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_bank <= 1'b0;
      r_m_row   <= '0;
    end else if (w_m_fire) begin
      r_rd_bank <= ~r_rd_bank;
      r_m_row   <= r_m_row + IDX_W'(1);
    end
  end

  always_comb begin
    for (int k = 0; k < int'(N); k++) begin
      m_data[k] = r_rd_bank ? w_data1[k] : w_data0[k];
    end
  end

  assign m_row = r_m_row;

endmodule

// File: tb/tb_dct_row_loader.sv
// Self-checking bench for dct_row_loader: vector table, directed corner sequences, random traffic vs a queue model.
module tb_dct_row_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data [7:0];
  logic [2:0] m_row;

  dct_row_loader dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_row   (m_row)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: rows waiting for the consumer plus the partially assembled row.
  typedef logic [7:0] row_arr_t [8];
  row_arr_t   rows_q [$];
  logic [7:0] part_q [$];
  int         drained = 0;

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       exp_ready;
    logic       exp_valid;
    logic [2:0] exp_row;
    logic [7:0] exp_d0;
    logic [7:0] exp_d7;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [7:0] ls(input logic [7:0] x);
`ifdef DCT_LEVEL_SHIFT_EN
    return {~x[7], x[6:0]};
`else
    return x;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_s_ready", 32'(s_ready), 32'(rows_q.size() < 2));
    check("model_m_valid", 32'(m_valid), 32'(rows_q.size() > 0));
    if (rows_q.size() > 0) begin
      check("model_m_row", 32'(m_row), 32'(drained % 8));
      for (int k = 0; k < 8; k++) begin
        check("model_m_data", 32'(m_data[k]), 32'(rows_q[0][k]));
      end
    end
  endtask

  task automatic model_step(input logic sv, input logic [7:0] sd, input logic mr);
    logic     rdy;
    row_arr_t tmp;
    rdy = (rows_q.size() < 2);
    if (rows_q.size() > 0 && mr) begin
      void'(rows_q.pop_front());
      drained++;
    end
    if (sv && rdy) begin
      part_q.push_back(ls(sd));
      if (part_q.size() == 8) begin
        for (int k = 0; k < 8; k++) tmp[k] = part_q[k];
        rows_q.push_back(tmp);
        part_q.delete();
      end
    end
  endtask

  // Apply inputs for one cycle: check pre-edge outputs, clock, update the model.
  task automatic drive_cycle(input logic sv, input logic [7:0] sd, input logic mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    check_model();
    @(posedge clk);
    model_step(sv, sd, mr);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rows_q.delete();
    part_q.delete();
    drained = 0;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_row", 32'(m_row), 32'd0);
    for (int k = 0; k < 8; k++) check("rst_m_data", 32'(m_data[k]), 32'd0);
  endtask

  int acc;
  int rowcnt;
  logic ready_now;
  logic [7:0] e0, e1, e2;

  initial begin
    for (int i = 0; i < 8; i++) begin
      vecs[i].sv        = 1'b1;
      vecs[i].sd        = 8'(i + 1);
      vecs[i].mr        = 1'b1;
      vecs[i].exp_ready = 1'b1;
      vecs[i].exp_valid = (i == 7);
      vecs[i].exp_row   = 3'd0;
      vecs[i].exp_d0    = ls(8'd1);
      vecs[i].exp_d7    = ls(8'd8);
    end
    vecs[8] = '{sv: 1'b0, sd: 8'h00, mr: 1'b1, exp_ready: 1'b1, exp_valid: 1'b0,
                exp_row: 3'd1, exp_d0: 8'h00, exp_d7: 8'h00};

    // Table: samples 1..8 with m_ready high, then one idle cycle.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_cycle(vecs[i].sv, vecs[i].sd, vecs[i].mr);
      check("tbl_s_ready", 32'(s_ready), 32'(vecs[i].exp_ready));
      check("tbl_m_valid", 32'(m_valid), 32'(vecs[i].exp_valid));
      check("tbl_m_row", 32'(m_row), 32'(vecs[i].exp_row));
      if (vecs[i].exp_valid) begin
        check("tbl_d0", 32'(m_data[0]), 32'(vecs[i].exp_d0));
        check("tbl_d7", 32'(m_data[7]), 32'(vecs[i].exp_d7));
      end
    end

    // 72 continuous samples: nine rows, m_row wraps back to 0.
    do_reset();
    rowcnt = 0;
    for (int i = 0; i < 72; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b1);
      if (m_valid) begin
        check("cont_m_row", 32'(m_row), 32'(rowcnt % 8));
        check("cont_d0", 32'(m_data[0]), 32'(ls(8'(8 * rowcnt))));
        check("cont_d7", 32'(m_data[7]), 32'(ls(8'(8 * rowcnt + 7))));
        rowcnt++;
      end
    end
    check("cont_rows", 32'(rowcnt), 32'd9);
    drive_cycle(1'b0, 8'h00, 1'b1);

    // Backpressure: 20 offers with m_ready low, 16 accepted; one-cycle drain pulse.
    do_reset();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      ready_now = s_ready;
      drive_cycle(1'b1, 8'(100 + acc), 1'b0);
      if (ready_now) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd16);
    check("bp_s_ready_low", 32'(s_ready), 32'd0);
    check("bp_row0_d0", 32'(m_data[0]), 32'(ls(8'd100)));
    drive_cycle(1'b0, 8'h00, 1'b1);
    check("bp_s_ready_after", 32'(s_ready), 32'd1);
    check("bp_row1_tag", 32'(m_row), 32'd1);
    check("bp_row1_d0", 32'(m_data[0]), 32'(ls(8'd108)));
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 8'h00, 1'b1);

    // Hold: row stays stable while the other bank fills; 8th sample lands with the drain.
    do_reset();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'(30 + i), 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b1, 8'(50 + i), 1'b0);
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_row", 32'(m_row), 32'd0);
      for (int k = 0; k < 8; k++) check("hold_data", 32'(m_data[k]), 32'(ls(8'(30 + k))));
    end
    drive_cycle(1'b1, 8'd57, 1'b1);
    check("swap_valid", 32'(m_valid), 32'd1);
    check("swap_row", 32'(m_row), 32'd1);
    check("swap_d0", 32'(m_data[0]), 32'(ls(8'd50)));
    check("swap_d7", 32'(m_data[7]), 32'(ls(8'd57)));
    drive_cycle(1'b0, 8'h00, 1'b1);

    // Reset mid-row discards the partial row.
    do_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(70 + i), 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'(200 + i), 1'b1);
    check("mid_rst_valid", 32'(m_valid), 32'd1);
    check("mid_rst_row", 32'(m_row), 32'd0);
    check("mid_rst_d0", 32'(m_data[0]), 32'(ls(8'd200)));
    check("mid_rst_d7", 32'(m_data[7]), 32'(ls(8'd207)));
    drive_cycle(1'b0, 8'h00, 1'b1);

    // Level-shift sample values.
`ifdef DCT_LEVEL_SHIFT_EN
    e0 = 8'h80; e1 = 8'h00; e2 = 8'h7F;
`else
    e0 = 8'h00; e1 = 8'h80; e2 = 8'hFF;
`endif
    do_reset();
    drive_cycle(1'b1, 8'h00, 1'b0);
    drive_cycle(1'b1, 8'h80, 1'b0);
    drive_cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(16 * i + 1), 1'b0);
    check("ls_d0", 32'(m_data[0]), 32'(e0));
    check("ls_d1", 32'(m_data[1]), 32'(e1));
    check("ls_d2", 32'(m_data[2]), 32'(e2));
    drive_cycle(1'b0, 8'h00, 1'b1);

    // Random traffic with varying source/sink duty cycles.
    do_reset();
    for (int blk = 0; blk < 10; blk++) begin
      for (int i = 0; i < 200; i++) begin
        drive_cycle(1'($urandom_range(0, 3) < 3 - (blk % 3)),
                    8'($urandom),
                    1'($urandom_range(0, 3) < 1 + (blk % 4)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
